// File: rtl/cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : cpu_multicycle
// Purpose  : Multi-cycle fetch/execute CPU. The instruction word is D+1 bits
//            wide and uses the legacy 9-bit encoding in its low bits. The core
//            has eight D-bit registers, a 2*D-bit PC and the flags {C,FL,FG,FE}.
//            ROM and RAM use request/valid handshakes, so either memory may
//            insert any number of wait states.
// Ports    : i_clk, i_rst              clock, synchronous active-high reset
//            o_rom_req/o_rom_addr      instruction fetch request and address
//            i_rom_valid/i_rom_data    fetch response
//            o_ram_req/o_ram_we        data access request; we=1 for STR
//            o_ram_addr/o_ram_data     {R2,R1} address and R0 write data
//            i_ram_valid/i_ram_data    access completion and LDR read data
//            o_halted, o_pc, o_flags   status and debug outputs
// Revision : 1.0 - initial release
// ============================================================================
module cpu_multicycle #(
  parameter int g_DATA_WIDTH = 8,
  parameter int g_ROM_ADDR   = 11,
  parameter int g_RAM_ADDR   = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  output logic                      o_rom_req,
  output logic [g_ROM_ADDR-1:0]     o_rom_addr,
  input  logic                      i_rom_valid,
  input  logic [g_DATA_WIDTH:0]     i_rom_data,
  output logic                      o_ram_req,
  output logic                      o_ram_we,
  output logic [g_RAM_ADDR-1:0]     o_ram_addr,
  output logic [g_DATA_WIDTH-1:0]   o_ram_data,
  input  logic                      i_ram_valid,
  input  logic [g_DATA_WIDTH-1:0]   i_ram_data,
  output logic                      o_halted,
  output logic [2*g_DATA_WIDTH-1:0] o_pc,
  output logic [3:0]                o_flags
);

  localparam int c_D  = g_DATA_WIDTH;
  localparam int c_I  = g_DATA_WIDTH + 1;
  localparam int c_PW = 2 * g_DATA_WIDTH;

  // Fixed 9-bit encodings; bit 0 clear distinguishes them from LD
  localparam logic [8:0] c_OP_JE  = 9'h008;
  localparam logic [8:0] c_OP_JG  = 9'h018;
  localparam logic [8:0] c_OP_JL  = 9'h028;
  localparam logic [8:0] c_OP_JMP = 9'h038;
  localparam logic [8:0] c_OP_ADD = 9'h048;
  localparam logic [8:0] c_OP_AND = 9'h058;
  localparam logic [8:0] c_OP_OR  = 9'h068;
  localparam logic [8:0] c_OP_NOT = 9'h078;
  localparam logic [8:0] c_OP_XOR = 9'h088;
  localparam logic [8:0] c_OP_LDR = 9'h098;
  localparam logic [8:0] c_OP_STR = 9'h0A8;
  localparam logic [8:0] c_OP_SUB = 9'h0C8;
  localparam logic [8:0] c_OP_ADC = 9'h0D8;
  localparam logic [8:0] c_OP_HLT = 9'h0F8;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [c_PW-1:0]  pc_q;
  logic [c_PW-1:0]  pc_d;
  logic [c_I-1:0]   ir_q;
  logic [c_D-1:0]   regs_q [8];
  logic             c_q;
  logic             fl_q;
  logic             fg_q;
  logic             fe_q;

  logic [c_D-1:0]   w_r0;
  logic [c_D-1:0]   w_r1;
  logic [c_D-1:0]   w_rx;
  logic [c_D-1:0]   w_ry;
  logic [c_D:0]     w_sum;
  logic [c_D:0]     w_sum_c;
  logic [c_D:0]     w_diff;
  logic [c_PW-1:0]  w_pc_inc;
  logic [c_PW-1:0]  w_jmp_tgt;
  logic             w_hi_zero;
  logic             w_is_str;

  logic             w_r0_we;
  logic [c_D-1:0]   w_r0_val;
  logic             w_mov_we;
  logic             w_cmp_we;
  logic             w_c_we;
  logic             w_c_val;

  assign w_r0      = regs_q[0];
  assign w_r1      = regs_q[1];
  assign w_rx      = regs_q[ir_q[8:6]];
  assign w_ry      = regs_q[ir_q[5:3]];
  // One extra bit catches the carry (ADD/ADC) or the borrow (SUB)
  assign w_sum     = {1'b0, w_r0} + {1'b0, w_r1};
  assign w_sum_c   = w_sum + {{c_D{1'b0}}, c_q};
  assign w_diff    = {1'b0, w_r0} - {1'b0, w_r1};
  assign w_pc_inc  = pc_q + {{(c_PW-1){1'b0}}, 1'b1};
  assign w_jmp_tgt = {w_r1, w_r0};
  // Bits above the legacy 9-bit field must be zero for non-LD opcodes
  assign w_hi_zero = ((ir_q >> 9) == '0);
  // Only LDR or STR can be in IR while in MEM, so the low bits are enough
  assign w_is_str  = (ir_q[8:0] == c_OP_STR);

  // Decode of the instruction in IR; used only in EXEC
  always_comb begin
    w_r0_we  = 1'b0;
    w_r0_val = w_r0;
    w_mov_we = 1'b0;
    w_cmp_we = 1'b0;
    w_c_we   = 1'b0;
    w_c_val  = c_q;
    pc_d     = w_pc_inc;
    state_d  = S_FETCH;
    if (ir_q[0]) begin
      w_r0_we  = 1'b1;
      w_r0_val = ir_q[c_I-1:1];
    end else if (w_hi_zero) begin
      if (ir_q[2:0] == 3'b100) begin
        w_mov_we = 1'b1;
      end else if (ir_q[2:0] == 3'b110) begin
        w_cmp_we = 1'b1;
      end else begin
        case (ir_q[8:0])
          c_OP_JE:  if (fe_q) pc_d = w_jmp_tgt;
          c_OP_JG:  if (fg_q) pc_d = w_jmp_tgt;
          c_OP_JL:  if (fl_q) pc_d = w_jmp_tgt;
          c_OP_JMP: pc_d = w_jmp_tgt;
          c_OP_ADD: begin
            w_r0_we  = 1'b1;
            w_r0_val = w_sum[c_D-1:0];
            w_c_we   = 1'b1;
            w_c_val  = w_sum[c_D];
          end
          c_OP_ADC: begin
            w_r0_we  = 1'b1;
            w_r0_val = w_sum_c[c_D-1:0];
            w_c_we   = 1'b1;
            w_c_val  = w_sum_c[c_D];
          end
          c_OP_SUB: begin
            w_r0_we  = 1'b1;
            w_r0_val = w_diff[c_D-1:0];
            w_c_we   = 1'b1;
            w_c_val  = w_diff[c_D];
          end
          c_OP_AND: begin
            w_r0_we  = 1'b1;
            w_r0_val = w_r0 & w_r1;
          end
          c_OP_OR: begin
            w_r0_we  = 1'b1;
            w_r0_val = w_r0 | w_r1;
          end
          c_OP_NOT: begin
            w_r0_we  = 1'b1;
            w_r0_val = ~w_r0;
          end
          c_OP_XOR: begin
            w_r0_we  = 1'b1;
            w_r0_val = w_r0 ^ w_r1;
          end
          // Memory ops and HLT hold the PC; MEM increments it on completion
          c_OP_LDR, c_OP_STR: begin
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          c_OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      c_q     <= 1'b0;
      fl_q    <= 1'b0;
      fg_q    <= 1'b0;
      fe_q    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (i_rom_valid) begin
            ir_q    <= i_rom_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_r0_we)  regs_q[0] <= w_r0_val;
          if (w_mov_we) regs_q[ir_q[8:6]] <= w_ry;
          if (w_cmp_we) begin
            fe_q <= (w_rx == w_ry);
            fg_q <= (w_rx >  w_ry);
            fl_q <= (w_rx <  w_ry);
          end
          if (w_c_we) c_q <= w_c_val;
          pc_q    <= pc_d;
          state_q <= state_d;
        end
        S_MEM: begin
          if (i_ram_valid) begin
            if (!w_is_str) regs_q[0] <= i_ram_data;
            pc_q    <= w_pc_inc;
            state_q <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Handshake and status outputs decode straight from the state register
  assign o_rom_req  = (state_q == S_FETCH);
  assign o_rom_addr = pc_q[g_ROM_ADDR-1:0];
  assign o_ram_req  = (state_q == S_MEM);
  assign o_ram_we   = (state_q == S_MEM) && w_is_str;
  assign o_ram_addr = g_RAM_ADDR'({regs_q[2], regs_q[1]});
  assign o_ram_data = w_r0;
  assign o_halted   = (state_q == S_HALT);
  assign o_pc       = pc_q;
  assign o_flags    = {c_q, fl_q, fg_q, fe_q};

endmodule
`default_nettype wire

// File: tb/tb_cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_multicycle
// Purpose  : Directed self-checking bench for cpu_multicycle at D=8, using
//            ROM and RAM responder models with programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_multicycle;

  logic        clk;
  logic        rst;
  logic        o_rom_req;
  logic [10:0] o_rom_addr;
  logic        i_rom_valid;
  logic [8:0]  i_rom_data;
  logic        o_ram_req;
  logic        o_ram_we;
  logic [10:0] o_ram_addr;
  logic [7:0]  o_ram_data;
  logic        i_ram_valid;
  logic [7:0]  i_ram_data;
  logic        o_halted;
  logic [15:0] o_pc;
  logic [3:0]  o_flags;

  int total;
  int bad;

  logic [8:0]  rom [0:2047];
  logic [7:0]  ram [0:2047];
  int          rom_wait;
  int          ram_wait;
  int          rom_cnt;
  int          ram_cnt;
  bit          rom_en;
  bit          ram_manual;
  logic        ram_man_valid;
  logic [7:0]  ram_man_data;
  logic        rom_valid_m;
  logic [8:0]  rom_data_m;
  logic        ram_valid_m;
  logic [7:0]  ram_data_m;

  cpu_multicycle #(
    .g_DATA_WIDTH(8),
    .g_ROM_ADDR  (11),
    .g_RAM_ADDR  (11)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_rom_req   (o_rom_req),
    .o_rom_addr  (o_rom_addr),
    .i_rom_valid (i_rom_valid),
    .i_rom_data  (i_rom_data),
    .o_ram_req   (o_ram_req),
    .o_ram_we    (o_ram_we),
    .o_ram_addr  (o_ram_addr),
    .o_ram_data  (o_ram_data),
    .i_ram_valid (i_ram_valid),
    .i_ram_data  (i_ram_data),
    .o_halted    (o_halted),
    .o_pc        (o_pc),
    .o_flags     (o_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responders update on the falling edge, away from the DUT edge
  always @(negedge clk) begin
    rom_valid_m = 1'b0;
    ram_valid_m = 1'b0;
    if (rst) begin
      rom_cnt = 0;
      ram_cnt = 0;
    end else begin
      if (o_rom_req && rom_en) begin
        if (rom_cnt >= rom_wait) begin
          rom_valid_m = 1'b1;
          rom_data_m  = rom[o_rom_addr];
          rom_cnt     = 0;
        end else begin
          rom_cnt++;
        end
      end else begin
        rom_cnt = 0;
      end
      if (o_ram_req) begin
        if (ram_cnt >= ram_wait) begin
          ram_valid_m = 1'b1;
          if (o_ram_we) ram[o_ram_addr] = o_ram_data;
          ram_data_m = ram[o_ram_addr];
          ram_cnt    = 0;
        end else begin
          ram_cnt++;
        end
      end else begin
        ram_cnt = 0;
      end
    end
  end

  assign i_rom_valid = rom_valid_m;
  assign i_rom_data  = rom_data_m;
  assign i_ram_valid = ram_manual ? ram_man_valid : ram_valid_m;
  assign i_ram_data  = ram_manual ? ram_man_data  : ram_data_m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 9'h0F8;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_until_halt(input int max, output int n);
    n = 0;
    while (!o_halted && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rom_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (o_rom_req !== 1'b1 || o_rom_addr !== 11'h0 || o_ram_req !== 1'b0 ||
        o_ram_we !== 1'b0 || o_halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rom_req=%b rom_addr=%h ram_req=%b we=%b halted=%b, need 1 000 0 0 0",
               o_rom_req, o_rom_addr, o_ram_req, o_ram_we, o_halted);
    end
    total++;
    if (o_flags !== 4'h0 || o_ram_data !== 8'h00 || o_pc !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: flags=%h ram_data=%h pc=%h, need 0 00 0000", o_flags, o_ram_data, o_pc);
    end
  endtask

  task automatic test_basic_program();
    int n;
    clear_rom();
    rom[0] = 9'h00B;  // LD 5
    rom[1] = 9'h044;  // MOV R1,R0
    rom[2] = 9'h007;  // LD 3
    rom[3] = 9'h048;  // ADD
    rom[4] = 9'h0F8;  // HLT
    rom_wait = 0;
    rom_en   = 1'b1;
    do_reset();
    run_until_halt(200, n);
    total++;
    if (n !== 10) begin
      bad++;
      $display("FAIL basic_cycles: got %0d, need 10", n);
    end
    total++;
    if (o_ram_data !== 8'h08 || o_ram_addr !== 11'h005) begin
      bad++;
      $display("FAIL basic_regs: R0=%h addr=%h, need 08 005", o_ram_data, o_ram_addr);
    end
    run_cycles(3);
    total++;
    if (o_halted !== 1'b1 || o_pc !== 16'h0004 || o_rom_req !== 1'b0 || o_ram_req !== 1'b0) begin
      bad++;
      $display("FAIL basic_halt: halted=%b pc=%h rom_req=%b ram_req=%b, need 1 0004 0 0",
               o_halted, o_pc, o_rom_req, o_ram_req);
    end
  endtask

  task automatic test_rom_wait();
    int   n;
    int   unstable;
    logic prev_req;
    logic [10:0] prev_addr;
    rom_wait  = 3;
    do_reset();
    n         = 0;
    unstable  = 0;
    prev_req  = 1'b0;
    prev_addr = '0;
    while (!o_halted && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (o_rom_req && prev_req && o_rom_addr !== prev_addr) unstable++;
      prev_req  = o_rom_req;
      prev_addr = o_rom_addr;
    end
    total++;
    if (n !== 25) begin
      bad++;
      $display("FAIL wait_cycles: got %0d, need 25", n);
    end
    total++;
    if (o_ram_data !== 8'h08 || o_pc !== 16'h0004) begin
      bad++;
      $display("FAIL wait_regs: R0=%h pc=%h, need 08 0004", o_ram_data, o_pc);
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL wait_addr_stable: %0d changes while waiting, need 0", unstable);
    end
    rom_wait = 0;
  endtask

  task automatic test_arith();
    int n;
    clear_rom();
    rom[0] = 9'h003;  // LD 1
    rom[1] = 9'h044;  // MOV R1,R0
    rom[2] = 9'h1FF;  // LD 0xFF
    rom[3] = 9'h048;  // ADD
    rom[4] = 9'h0D8;  // ADC
    rom[5] = 9'h005;  // LD 2
    rom[6] = 9'h044;  // MOV R1,R0
    rom[7] = 9'h003;  // LD 1
    rom[8] = 9'h0C8;  // SUB
    rom[9] = 9'h0F8;  // HLT
    do_reset();
    run_cycles(8);
    total++;
    if (o_ram_data !== 8'h00 || o_flags !== 4'b1000) begin
      bad++;
      $display("FAIL add_carry: R0=%h flags=%b, need 00 1000", o_ram_data, o_flags);
    end
    run_cycles(2);
    total++;
    if (o_ram_data !== 8'h02 || o_flags !== 4'b0000) begin
      bad++;
      $display("FAIL adc: R0=%h flags=%b, need 02 0000", o_ram_data, o_flags);
    end
    run_until_halt(200, n);
    total++;
    if (o_ram_data !== 8'hFF || o_flags !== 4'b1000 || o_ram_addr !== 11'h002) begin
      bad++;
      $display("FAIL sub_borrow: R0=%h flags=%b R1addr=%h, need FF 1000 002",
               o_ram_data, o_flags, o_ram_addr);
    end
  endtask

  task automatic test_mem();
    int n;
    int we_cnt;
    int we_stray;
    int addr_bad;
    int wdata_bad;
    clear_rom();
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    rom[0] = 9'h047;  // LD 0x23
    rom[1] = 9'h044;  // MOV R1,R0
    rom[2] = 9'h003;  // LD 0x01
    rom[3] = 9'h084;  // MOV R2,R0
    rom[4] = 9'h14B;  // LD 0xA5
    rom[5] = 9'h0A8;  // STR
    rom[6] = 9'h001;  // LD 0
    rom[7] = 9'h098;  // LDR
    rom[8] = 9'h0F8;  // HLT
    ram_wait = 2;
    do_reset();
    n = 0; we_cnt = 0; we_stray = 0; addr_bad = 0; wdata_bad = 0;
    while (!o_halted && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (o_ram_req && o_ram_we) begin
        we_cnt++;
        if (o_ram_data !== 8'hA5) wdata_bad++;
      end
      if (o_ram_we && !o_ram_req) we_stray++;
      if (o_ram_req && o_ram_addr !== 11'h123) addr_bad++;
    end
    total++;
    if (n !== 24) begin
      bad++;
      $display("FAIL mem_cycles: got %0d, need 24", n);
    end
    total++;
    if (we_cnt !== 3 || we_stray !== 0) begin
      bad++;
      $display("FAIL mem_we: we cycles=%0d stray=%0d, need 3 0", we_cnt, we_stray);
    end
    total++;
    if (addr_bad !== 0 || wdata_bad !== 0 || ram[11'h123] !== 8'hA5) begin
      bad++;
      $display("FAIL mem_write: bad addr=%0d bad data=%0d ram[123]=%h, need 0 0 A5",
               addr_bad, wdata_bad, ram[11'h123]);
    end
    total++;
    if (o_ram_data !== 8'hA5 || o_pc !== 16'h0008) begin
      bad++;
      $display("FAIL mem_ldr: R0=%h pc=%h, need A5 0008", o_ram_data, o_pc);
    end
    ram_wait = 0;
  endtask

  task automatic test_branch();
    int n;
    clear_rom();
    rom[0] = 9'h009;  // LD 4
    rom[1] = 9'h084;  // MOV R2,R0
    rom[2] = 9'h013;  // LD 9
    rom[3] = 9'h0C4;  // MOV R3,R0
    rom[4] = 9'h09E;  // CMP R2,R3
    rom[5] = 9'h021;  // LD 0x10
    rom[6] = 9'h008;  // JE  (not taken)
    rom[7] = 9'h028;  // JL  (taken)
    rom[16] = 9'h0F8; // HLT
    do_reset();
    run_cycles(10);
    total++;
    if (o_flags !== 4'b0100) begin
      bad++;
      $display("FAIL cmp_flags: got %b, need 0100", o_flags);
    end
    run_cycles(4);
    total++;
    if (o_rom_addr !== 11'h007 || o_pc !== 16'h0007) begin
      bad++;
      $display("FAIL je_not_taken: rom_addr=%h pc=%h, need 007 0007", o_rom_addr, o_pc);
    end
    run_cycles(2);
    total++;
    if (o_rom_addr !== 11'h010 || o_rom_req !== 1'b1) begin
      bad++;
      $display("FAIL jl_taken: rom_addr=%h req=%b, need 010 1", o_rom_addr, o_rom_req);
    end
    run_until_halt(50, n);
    total++;
    if (n !== 2 || o_pc !== 16'h0010) begin
      bad++;
      $display("FAIL jl_target_halt: cycles=%0d pc=%h, need 2 0010", n, o_pc);
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    clear_rom();
    rom[0] = 9'h00F;  // LD 7
    rom[1] = 9'h098;  // LDR
    ram_manual    = 1'b1;
    ram_man_valid = 1'b0;
    ram_man_data  = 8'h5A;
    do_reset();
    run_cycles(7);
    total++;
    if (o_ram_req !== 1'b1 || o_ram_we !== 1'b0 || o_ram_data !== 8'h07) begin
      bad++;
      $display("FAIL mid_mem_wait: req=%b we=%b R0=%h, need 1 0 07", o_ram_req, o_ram_we, o_ram_data);
    end
    rom_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (o_rom_req !== 1'b1 || o_rom_addr !== 11'h0 || o_ram_req !== 1'b0 || o_ram_we !== 1'b0 ||
        o_halted !== 1'b0 || o_flags !== 4'h0 || o_ram_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_mem_reset: rom_req=%b addr=%h ram_req=%b we=%b halted=%b flags=%h R0=%h, need 1 000 0 0 0 0 00",
               o_rom_req, o_rom_addr, o_ram_req, o_ram_we, o_halted, o_flags, o_ram_data);
    end
    rst = 1'b0;
    ram_man_valid = 1'b1;
    run_cycles(2);
    ram_man_valid = 1'b0;
    total++;
    if (o_ram_data !== 8'h00 || o_rom_req !== 1'b1 || o_ram_req !== 1'b0 || o_pc !== 16'h0) begin
      bad++;
      $display("FAIL late_valid: R0=%h rom_req=%b ram_req=%b pc=%h, need 00 1 0 0000",
               o_ram_data, o_rom_req, o_ram_req, o_pc);
    end
    rom[0] = 9'h0B8;  // NOP
    rom[1] = 9'h0F8;  // HLT
    rom_en = 1'b1;
    run_until_halt(50, n);
    total++;
    if (n !== 4 || o_ram_data !== 8'h00 || o_pc !== 16'h0001) begin
      bad++;
      $display("FAIL refetch: cycles=%0d R0=%h pc=%h, need 4 00 0001", n, o_ram_data, o_pc);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    rom_en        = 1'b0;
    rom_wait      = 0;
    ram_wait      = 0;
    rom_cnt       = 0;
    ram_cnt       = 0;
    ram_manual    = 1'b0;
    ram_man_valid = 1'b0;
    ram_man_data  = 8'h00;
    rom_valid_m   = 1'b0;
    rom_data_m    = 9'h000;
    ram_valid_m   = 1'b0;
    ram_data_m    = 8'h00;
    clear_rom();
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;

    test_reset();
    test_basic_program();
    test_rom_wait();
    test_arith();
    test_mem();
    test_branch();
    test_reset_mid_mem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised successor to the single-cycle 9-bit core: a multi-cycle fetch/execute CPU with a generic data width, request/valid handshakes to ROM and RAM (arbitrary wait states), a HALT state, and SUB/ADC/HLT instructions. It sits between the program ROM and the data RAM. It keeps the existing instruction encoding in the low 9 bits, so current programs run unchanged at g_DATA_WIDTH=8 (NOT becomes bitwise).

## Interface
- g_DATA_WIDTH, 8: register width D (≥8); instruction width I = D+1; PC width 2·D.
- g_ROM_ADDR, 11: ROM address width (≤2·D); o_rom_addr = PC[g_ROM_ADDR-1:0].
- g_RAM_ADDR, 11: RAM address width (≤2·D); o_ram_addr = {R2,R1}[g_RAM_ADDR-1:0].
- i_clk  in  1  single clock; all state changes on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- o_rom_req  out  1  fetch request; held until accepted.
- o_rom_addr  out  g_ROM_ADDR  fetch address.
- i_rom_valid  in  1  i_rom_data valid this cycle; accepted only while o_rom_req=1.
- i_rom_data  in  I  instruction word.
- o_ram_req  out  1  RAM access request; held until accepted.
- o_ram_we  out  1  1=write (STR), 0=read (LDR); valid only while o_ram_req=1.
- o_ram_addr  out  g_RAM_ADDR  access address.
- o_ram_data  out  D  write data, always R0.
- i_ram_valid  in  1  access complete / i_ram_data valid; ignored while o_ram_req=0.
- i_ram_data  in  D  read data.
- o_halted  out  1  core is in HALT.
- o_pc  out  2·D  debug copy of PC.
- o_flags  out  4  {C,FL,FG,FE}.

## Operation
- States: FETCH, EXEC, MEM, HALT. Reset → FETCH, PC=0, R0..R7=0, flags=0, IR=0.
- FETCH: o_rom_req=1. On i_rom_valid: IR←i_rom_data, go to EXEC. Otherwise stay in FETCH.
- EXEC: decode IR.
  - LD: IR[0]=1 → R0←IR[I-1:1].
  - All other opcodes: upper bits IR[I-1:9] must be 0; if not, execute as NOP.
  - Low-9-bit encodings, unchanged: MOV xxx_yyy_100 (Rx←Ry); CMP xxx_yyy_110; JE 0000_0100_0; JG 0000_1100_0; JL 0001_0100_0; JMP 0001_1100_0; ADD 0010_0100_0; AND 0010_1100_0; OR 0011_0100_0; NOT 0011_1100_0 (bitwise ~R0); XOR 0100_0100_0; LDR 0100_1100_0; STR 0101_0100_0; NOP 0101_1100_0.
  - New encodings: SUB 0110_0100_0 (R0←R0−R1); ADC 0110_1100_0 (R0←R0+R1+C); HLT 0111_1100_0. Any other encoding executes as NOP.
  - Jumps: target PC={R1,R0}. A not-taken jump gives PC+1.
  - LDR/STR: go to MEM; PC is not yet incremented.
  - HLT: go to HALT; PC is not incremented.
  - Everything else: PC←PC+1 (or the jump target), then FETCH.
- MEM: o_ram_req=1, o_ram_we=1 for STR and 0 for LDR. Address and data stay stable until i_ram_valid. On i_ram_valid: LDR writes R0←i_ram_data, PC←PC+1, then FETCH.
- HALT: o_halted=1, no requests issued. Only i_rst leaves HALT.
- Arithmetic:
  - All operations are unsigned D-bit and wrap modulo 2^D.
  - ADD/ADC: C←carry out of bit D-1.
  - SUB: C←borrow (1 iff R0<R1).
  - CMP: FE/FG/FL←(Rx==Ry)/(Rx>Ry)/(Rx<Ry). Only CMP changes FE/FG/FL; only ADD/ADC/SUB change C.
- PC wraps from 2^(2D)−1 to 0. ROM address truncation is silent.

## Timing
- Zero-wait memory: valid may be asserted in the same cycle as req.
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - LDR/STR: 3 cycles.
  - Each ROM/RAM wait cycle adds one cycle.
- Requests are driven combinationally from the state register. They deassert in the cycle after acceptance and never drop before valid.
- EXEC performs its register/flag/PC writes at the end of the EXEC cycle. The next fetch address is the updated PC.
- i_rst=1 at any edge overrides all activity, including mid-MEM and HALT.
  - Next cycle: state FETCH, all outputs at reset values: o_rom_req=1, o_rom_addr=0, o_ram_req=0, o_ram_we=0, o_halted=0, o_flags=0, o_ram_data=0.
  - The response to an abandoned request is ignored.
- Valid pulses that arrive while the matching req=0 are ignored.

## Test plan
- Reset, ROM with zero wait: LD 5; LD→R1 via MOV; LD 3; ADD; HLT → R0=8, o_halted=1 after exactly 10 cycles, o_pc=4.
- ROM valid delayed 3 cycles on every fetch → same register results; each instruction takes +3 cycles; o_rom_addr stable while waiting.
- D=8: R0=0xFF, R1=0x01; ADD, then ADC → R0=0x00 with C=1, then R0=0x02 with C=0. SUB of 0x01−0x02 → R0=0xFF, C=1.
- STR to {R2,R1}=0x0123 with R0=0xA5, RAM valid after 2 cycles, then LDR → o_ram_we=1 only during the STR MEM cycles; R0=0xA5 read back.
- CMP 4 vs 9, then JL to {R1,R0}=0x0010 → FL=1 and next o_rom_addr=0x010. JE in the same state → not taken, PC+1.
- Assert i_rst during LDR MEM wait; later pulse i_ram_valid → core refetches from PC 0; R0 stays 0; the late valid is ignored.
